// File: rtl/memory_stage_ctrl_pkg.sv
// rtl/memory_stage_ctrl_pkg.sv - shared word width, FSM encodings and MEM/WB slot type
package memory_stage_ctrl_pkg;

    localparam int WORD_W           = 16;
    localparam int MAX_WAIT_DEFAULT = 15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    typedef struct packed {
        logic [WORD_W-1:0] writeData;
        logic [2:0]        writeRegister;
        logic              registerWrite;
        logic              halt;
        logic              createDump;
    } slot_t;

    // Link beats memory data, which beats the ALU result; stores never write back.
    function automatic slot_t buildSlot(
        input logic [WORD_W-1:0] xOut,
        input logic [WORD_W-1:0] plusTwoPC,
        input logic [WORD_W-1:0] memData,
        input logic              link,
        input logic              memoryToRegister,
        input logic              registerWrite,
        input logic              isStore,
        input logic              halt,
        input logic              createDump,
        input logic [2:0]        writeRegister
    );
        slot_t s;
        if (link)
            s.writeData = plusTwoPC;
        else if (memoryToRegister)
            s.writeData = memData;
        else
            s.writeData = xOut;
        s.writeRegister = writeRegister;
        s.registerWrite = registerWrite & ~isStore;
        s.halt          = halt;
        s.createDump    = createDump;
        return s;
    endfunction

endpackage

// File: rtl/memory_stage_ctrl_memwb_slot.sv
// rtl/memory_stage_ctrl_memwb_slot.sv - registered MEM/WB output bank, cleared whenever the slot is empty
module memwb_slot
    import memory_stage_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  slot_t inSlot,
    input  logic  inValid,
    output slot_t outSlot,
    output logic  outValid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outSlot  <= '0;
            outValid <= 1'b0;
        end else begin
            outValid <= inValid;
            outSlot  <= inValid ? inSlot : '0;
        end
    end

endmodule

// File: rtl/memory_stage_ctrl.sv
// rtl/memory_stage_ctrl.sv - MEM stage controller: issues data-memory requests, waits on memDone, emits MEM/WB slot
module memory_stage_ctrl
    import memory_stage_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] inXOut,
    input  logic [WORD_W-1:0] inRead2Data,
    input  logic [WORD_W-1:0] inPlusTwoPC,
    input  logic              inMemoryWrite,
    input  logic              inMemoryRead,
    input  logic              inMemoryToRegister,
    input  logic              inRegisterWrite,
    input  logic              inHalt,
    input  logic              inCreateDump,
    input  logic              inLink,
    input  logic [2:0]        inWriteRegister,
    input  logic              inValid,
    output logic              memEnable,
    output logic              memWr,
    output logic [WORD_W-1:0] memAddr,
    output logic [WORD_W-1:0] memWriteData,
    input  logic [WORD_W-1:0] memDataOut,
    input  logic              memDone,
    input  logic              memStall,
    output logic              stall,
    output logic [WORD_W-1:0] outWriteData,
    output logic [2:0]        outWriteRegister,
    output logic              outRegisterWrite,
    output logic              outHalt,
    output logic              outCreateDump,
    output logic              outValid,
    output logic              outErr
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [1:0]        state, stateNext;
    logic [CW-1:0]     waitCount, waitCountNext;
    logic              halted, haltedNext;
    logic              capture;
    logic              isMemop;
    slot_t             slotData, slotOut;
    logic              slotValid;

    logic [WORD_W-1:0] latchXOut, latchPlusTwoPC;
    logic [2:0]        latchWriteRegister;
    logic              latchRegisterWrite, latchHalt, latchCreateDump;
    logic              latchLink, latchMemoryToRegister, latchIsStore;

    // Completion is defined by memDone alone; memStall is only observed.
    logic memStallUnused;
    assign memStallUnused = memStall;

    assign isMemop = inValid & (inMemoryRead | inMemoryWrite);

    always_comb begin
        stateNext     = state;
        waitCountNext = waitCount;
        haltedNext    = halted;
        capture       = 1'b0;
        memEnable     = 1'b0;
        memWr         = 1'b0;
        memAddr       = '0;
        memWriteData  = '0;
        stall         = 1'b0;
        slotValid     = 1'b0;
        slotData      = '0;

        case (state)
            ST_IDLE: begin
                if (halted) begin
                    stall = 1'b1;
                end else if (isMemop && inXOut[0]) begin
                    stall     = 1'b1;
                    stateNext = ST_ERR;
                end else if (isMemop) begin
                    memEnable     = 1'b1;
                    memWr         = inMemoryWrite;
                    memAddr       = inXOut;
                    memWriteData  = inRead2Data;
                    capture       = 1'b1;
                    waitCountNext = '0;
                    if (memDone) begin
                        slotValid = 1'b1;
                        slotData  = buildSlot(inXOut, inPlusTwoPC, memDataOut, inLink,
                                              inMemoryToRegister, inRegisterWrite, inMemoryWrite,
                                              inHalt, inCreateDump, inWriteRegister);
                    end else begin
                        stall     = 1'b1;
                        stateNext = ST_WAIT;
                    end
                end else begin
                    slotValid = inValid;
                    slotData  = buildSlot(inXOut, inPlusTwoPC, memDataOut, inLink,
                                          inMemoryToRegister, inRegisterWrite, 1'b0,
                                          inHalt, inCreateDump, inWriteRegister);
                end
            end
            ST_WAIT: begin
                waitCountNext = waitCount + CW'(1);
                if (memDone) begin
                    slotValid = 1'b1;
                    slotData  = buildSlot(latchXOut, latchPlusTwoPC, memDataOut, latchLink,
                                          latchMemoryToRegister, latchRegisterWrite, latchIsStore,
                                          latchHalt, latchCreateDump, latchWriteRegister);
                    stateNext = ST_IDLE;
                end else begin
                    stall = 1'b1;
                    if (waitCount == CW'(MAX_WAIT - 1))
                        stateNext = ST_ERR;
                end
            end
            ST_ERR: begin
                stall = 1'b1;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase

        // Combinational outputs must read as idle while reset is held, regardless of inputs.
        if (!rst) begin
            stall        = 1'b0;
            memEnable    = 1'b0;
            memWr        = 1'b0;
            memAddr      = '0;
            memWriteData = '0;
            slotValid    = 1'b0;
            capture      = 1'b0;
        end

        if (slotValid && slotData.halt)
            haltedNext = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            waitCount <= '0;
            halted    <= 1'b0;
        end else begin
            state     <= stateNext;
            waitCount <= waitCountNext;
            halted    <= haltedNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            latchXOut             <= '0;
            latchPlusTwoPC        <= '0;
            latchWriteRegister    <= '0;
            latchRegisterWrite    <= 1'b0;
            latchHalt             <= 1'b0;
            latchCreateDump       <= 1'b0;
            latchLink             <= 1'b0;
            latchMemoryToRegister <= 1'b0;
            latchIsStore          <= 1'b0;
        end else if (capture) begin
            latchXOut             <= inXOut;
            latchPlusTwoPC        <= inPlusTwoPC;
            latchWriteRegister    <= inWriteRegister;
            latchRegisterWrite    <= inRegisterWrite;
            latchHalt             <= inHalt;
            latchCreateDump       <= inCreateDump;
            latchLink             <= inLink;
            latchMemoryToRegister <= inMemoryToRegister;
            latchIsStore          <= inMemoryWrite;
        end
    end

    memwb_slot uSlot (
        .clk      (clk),
        .rst      (rst),
        .inSlot   (slotData),
        .inValid  (slotValid),
        .outSlot  (slotOut),
        .outValid (outValid)
    );

    assign outWriteData     = slotOut.writeData;
    assign outWriteRegister = slotOut.writeRegister;
    assign outRegisterWrite = slotOut.registerWrite;
    assign outHalt          = slotOut.halt;
    assign outCreateDump    = slotOut.createDump;
    assign outErr           = (state == ST_ERR);

endmodule

// File: tb/tb_memory_stage_ctrl.sv
// tb/tb_memory_stage_ctrl.sv - directed-vector bench for memory_stage_ctrl
module tb_memory_stage_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] inXOut, inRead2Data, inPlusTwoPC;
    logic        inMemoryWrite, inMemoryRead, inMemoryToRegister, inRegisterWrite;
    logic        inHalt, inCreateDump, inLink, inValid;
    logic [2:0]  inWriteRegister;
    logic        memEnable, memWr;
    logic [15:0] memAddr, memWriteData, memDataOut;
    logic        memDone, memStall;
    logic        stall;
    logic [15:0] outWriteData;
    logic [2:0]  outWriteRegister;
    logic        outRegisterWrite, outHalt, outCreateDump, outValid, outErr;

    int vectors    = 0;
    int miscompares = 0;
    int stallCnt, enCnt, waitCycles;

    memory_stage_ctrl #(.MAX_WAIT(15)) dut (
        .clk                (clk),
        .rst                (rst),
        .inXOut             (inXOut),
        .inRead2Data        (inRead2Data),
        .inPlusTwoPC        (inPlusTwoPC),
        .inMemoryWrite      (inMemoryWrite),
        .inMemoryRead       (inMemoryRead),
        .inMemoryToRegister (inMemoryToRegister),
        .inRegisterWrite    (inRegisterWrite),
        .inHalt             (inHalt),
        .inCreateDump       (inCreateDump),
        .inLink             (inLink),
        .inWriteRegister    (inWriteRegister),
        .inValid            (inValid),
        .memEnable          (memEnable),
        .memWr              (memWr),
        .memAddr            (memAddr),
        .memWriteData       (memWriteData),
        .memDataOut         (memDataOut),
        .memDone            (memDone),
        .memStall           (memStall),
        .stall              (stall),
        .outWriteData       (outWriteData),
        .outWriteRegister   (outWriteRegister),
        .outRegisterWrite   (outRegisterWrite),
        .outHalt            (outHalt),
        .outCreateDump      (outCreateDump),
        .outValid           (outValid),
        .outErr             (outErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearInputs();
        inXOut = '0; inRead2Data = '0; inPlusTwoPC = '0;
        inMemoryWrite = 0; inMemoryRead = 0; inMemoryToRegister = 0; inRegisterWrite = 0;
        inHalt = 0; inCreateDump = 0; inLink = 0; inValid = 0; inWriteRegister = '0;
        memDataOut = '0; memDone = 0; memStall = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic doReset();
        tick();
        rst = 0;
        clearInputs();
        tick();
        rst = 1;
    endtask

    initial begin
        clearInputs();
        rst = 0;
        inValid = 1; inMemoryRead = 1; inXOut = 16'h0040;
        sample();
        checkVal("rst_memEnable", memEnable, 0);
        checkVal("rst_memWr", memWr, 0);
        checkVal("rst_stall", stall, 0);
        checkVal("rst_outValid", outValid, 0);
        checkVal("rst_outErr", outErr, 0);
        checkVal("rst_outWriteData", outWriteData, 0);
        clearInputs();
        tick();
        rst = 1;

        // plain ALU op
        tick();
        inValid = 1; inXOut = 16'h1234; inRegisterWrite = 1; inWriteRegister = 3'd3;
        sample();
        checkVal("alu_stall", stall, 0);
        checkVal("alu_memEnable", memEnable, 0);
        tick();
        clearInputs();
        sample();
        checkVal("alu_outValid", outValid, 1);
        checkVal("alu_outWriteData", outWriteData, 16'h1234);
        checkVal("alu_outRegisterWrite", outRegisterWrite, 1);
        checkVal("alu_outWriteRegister", outWriteRegister, 3);
        checkVal("alu_stall_after", stall, 0);
        tick();
        sample();
        checkVal("bubble_outValid", outValid, 0);

        // load, memDone three cycles after issue; inputs change while waiting
        tick();
        inValid = 1; inMemoryRead = 1; inMemoryToRegister = 1; inRegisterWrite = 1;
        inWriteRegister = 3'd5; inXOut = 16'h0040;
        stallCnt = 0; enCnt = 0;
        for (int c = 0; c < 4; c++) begin
            sample();
            if (c == 0) begin
                checkVal("ld_memAddr", memAddr, 16'h0040);
                checkVal("ld_memWr", memWr, 0);
            end
            if (c == 1) checkVal("ld_wait_outValid", outValid, 0);
            stallCnt += int'(stall);
            enCnt    += int'(memEnable);
            tick();
            if (c == 0) begin
                inMemoryRead = 0; inMemoryWrite = 1; inXOut = 16'h0080; inRead2Data = 16'hDEAD;
            end
            if (c == 2) begin
                memDone = 1; memDataOut = 16'hBEEF;
            end
            if (c == 3) clearInputs();
        end
        sample();
        checkVal("ld_stall_cycles", stallCnt, 3);
        checkVal("ld_enable_pulses", enCnt, 1);
        checkVal("ld_outValid", outValid, 1);
        checkVal("ld_outWriteData", outWriteData, 16'hBEEF);
        checkVal("ld_outWriteRegister", outWriteRegister, 5);
        checkVal("ld_outRegisterWrite", outRegisterWrite, 1);

        // store completing in its issue cycle
        tick();
        inValid = 1; inMemoryWrite = 1; inRegisterWrite = 1; inWriteRegister = 3'd2;
        inXOut = 16'h0010; inRead2Data = 16'h5A5A; memDone = 1;
        sample();
        checkVal("st_memEnable", memEnable, 1);
        checkVal("st_memWr", memWr, 1);
        checkVal("st_memAddr", memAddr, 16'h0010);
        checkVal("st_memWriteData", memWriteData, 16'h5A5A);
        checkVal("st_stall", stall, 0);
        tick();
        clearInputs();
        sample();
        checkVal("st_outValid", outValid, 1);
        checkVal("st_outRegisterWrite", outRegisterWrite, 0);

        // bubble carrying stray control bits
        tick();
        inMemoryRead = 1; inHalt = 1; inRegisterWrite = 1; inCreateDump = 1;
        sample();
        checkVal("bub_memEnable", memEnable, 0);
        checkVal("bub_stall", stall, 0);
        tick();
        clearInputs();
        sample();
        checkVal("bub_outValid", outValid, 0);
        checkVal("bub_outHalt", outHalt, 0);
        checkVal("bub_outRegisterWrite", outRegisterWrite, 0);
        checkVal("bub_outCreateDump", outCreateDump, 0);

        // read and write both set: write wins
        tick();
        inValid = 1; inMemoryRead = 1; inMemoryWrite = 1; inRegisterWrite = 1; inMemoryToRegister = 1;
        inXOut = 16'h0020; memDone = 1; memDataOut = 16'h7777;
        sample();
        checkVal("rw_memWr", memWr, 1);
        tick();
        clearInputs();
        sample();
        checkVal("rw_outValid", outValid, 1);
        checkVal("rw_outRegisterWrite", outRegisterWrite, 0);

        // JAL-style link
        tick();
        inValid = 1; inLink = 1; inPlusTwoPC = 16'h0102; inXOut = 16'h0998;
        inRegisterWrite = 1; inWriteRegister = 3'd7; inMemoryToRegister = 1; memDataOut = 16'h3333;
        sample();
        checkVal("jal_stall", stall, 0);
        tick();
        clearInputs();
        sample();
        checkVal("jal_outWriteData", outWriteData, 16'h0102);
        checkVal("jal_outWriteRegister", outWriteRegister, 7);

        // reset dropped mid-WAIT, then a late memDone
        tick();
        inValid = 1; inMemoryRead = 1; inMemoryToRegister = 1; inRegisterWrite = 1; inXOut = 16'h0060;
        sample();
        checkVal("rw8_memEnable", memEnable, 1);
        tick();
        clearInputs();
        sample();
        checkVal("rw8_wait_stall", stall, 1);
        tick();
        rst = 0;
        #1;
        checkVal("midrst_stall", stall, 0);
        checkVal("midrst_memEnable", memEnable, 0);
        checkVal("midrst_outValid", outValid, 0);
        checkVal("midrst_outErr", outErr, 0);
        tick();
        rst = 1; memDone = 1; memDataOut = 16'hCAFE;
        sample();
        checkVal("late_stall", stall, 0);
        checkVal("late_memEnable", memEnable, 0);
        tick();
        memDone = 0; memDataOut = '0;
        inValid = 1; inXOut = 16'h0776; inRegisterWrite = 1;
        sample();
        checkVal("late_outValid", outValid, 0);
        checkVal("late_outWriteData", outWriteData, 0);
        checkVal("late_idle_stall", stall, 0);
        tick();
        clearInputs();
        sample();
        checkVal("late_alu_outValid", outValid, 1);
        checkVal("late_alu_outWriteData", outWriteData, 16'h0776);

        // timeout: memDone never arrives
        doReset();
        tick();
        inValid = 1; inMemoryRead = 1; inXOut = 16'h0100;
        sample();
        checkVal("to_memEnable", memEnable, 1);
        tick();
        clearInputs();
        waitCycles = 0;
        for (int k = 0; k < 40; k++) begin
            sample();
            if (outErr) break;
            waitCycles++;
            tick();
        end
        checkVal("to_wait_cycles", waitCycles, 15);
        checkVal("to_outErr", outErr, 1);
        checkVal("to_stall", stall, 1);
        tick();
        memDone = 1;
        sample();
        checkVal("err_done_stall", stall, 1);
        tick();
        memDone = 0;
        sample();
        checkVal("err_done_outValid", outValid, 0);
        checkVal("err_done_outErr", outErr, 1);

        // misaligned store
        doReset();
        sample();
        checkVal("rst2_outErr", outErr, 0);
        tick();
        inValid = 1; inMemoryWrite = 1; inRegisterWrite = 1; inXOut = 16'h0003; inRead2Data = 16'h1111;
        sample();
        checkVal("mis_memEnable", memEnable, 0);
        checkVal("mis_stall", stall, 1);
        checkVal("mis_outErr_now", outErr, 0);
        tick();
        clearInputs();
        inValid = 1; inXOut = 16'h0042; inRegisterWrite = 1;
        sample();
        checkVal("mis_outErr", outErr, 1);
        checkVal("mis_outValid", outValid, 0);
        repeat (4) tick();
        sample();
        checkVal("mis_stall_held", stall, 1);
        checkVal("mis_outValid_held", outValid, 0);
        doReset();
        sample();
        checkVal("mis_rst_outErr", outErr, 0);
        checkVal("mis_rst_stall", stall, 0);

        // halt blocks further memops
        tick();
        inValid = 1; inHalt = 1; inXOut = 16'h0004;
        sample();
        checkVal("halt_stall", stall, 0);
        tick();
        clearInputs();
        inValid = 1; inMemoryRead = 1; inXOut = 16'h0040; memDone = 1;
        sample();
        checkVal("halt_outHalt", outHalt, 1);
        checkVal("halt_outValid", outValid, 1);
        checkVal("halt_memEnable", memEnable, 0);
        checkVal("halt_stall_memop", stall, 1);
        tick();
        sample();
        checkVal("halt_after_outValid", outValid, 0);
        checkVal("halt_after_stall", stall, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_stage_ctrl.md
MEMORY_STAGE_CTRL -- requirements
Module: memory_stage_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, the number of WAIT cycles without memDone before timeout.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have input ports inXOut[16], inRead2Data[16] and inPlusTwoPC[16]: EX/MEM ALU result (address), store data and PC+2.
REQ-005 SHALL have input ports inMemoryWrite, inMemoryRead, inMemoryToRegister, inRegisterWrite, inHalt, inCreateDump, inLink (1 bit each) and inWriteRegister[3]: EX/MEM control.
REQ-006 SHALL have input port inValid, 1 bit: the EX/MEM slot holds a real instruction (0 = bubble).
REQ-007 SHALL have output ports memEnable, memWr (1 bit each), memAddr[16] and memWriteData[16]: data-memory request.
REQ-008 SHALL have input ports memDataOut[16], memDone and memStall (1 bit each): memory read data, completion pulse and busy indication.
REQ-009 SHALL have output port stall, 1 bit: upstream stages must hold; the EX/MEM register keeps its value.
REQ-010 SHALL have output ports outWriteData[16], outWriteRegister[3], outRegisterWrite, outHalt, outCreateDump and outValid: the registered MEM/WB slot.
REQ-011 SHALL have output port outErr, 1 bit: sticky fault flag (misalignment or timeout).

Function
REQ-012 SHALL implement FSM states IDLE, WAIT and ERR; state encodings SHALL come from the shared package.
REQ-013 SHALL treat a slot as a memop when inValid=1 and (inMemoryRead or inMemoryWrite) is 1; when both read and write are set, write SHALL take priority.
REQ-014 SHALL, in IDLE with a non-memop, register the MEM/WB slot next edge with stall=0, giving 1-cycle latency.
REQ-015 SHALL, in IDLE with a memop and inXOut[0]=0, drive memEnable=1, memWr=inMemoryWrite, memAddr=inXOut and memWriteData=inRead2Data for exactly one cycle, and latch all inputs.
REQ-016 SHALL, when memDone=1 in the issue cycle, complete the memop next edge with stall=0 and stay in IDLE.
REQ-017 SHALL otherwise go to WAIT; in WAIT it SHALL hold stall=1, memEnable=0, outValid=0 and ignore in* inputs.
REQ-018 SHALL, in WAIT on memDone=1, register the slot from the latched fields plus memDataOut, deassert stall that cycle (combinationally) and return to IDLE.
REQ-019 SHALL run a wait counter that clears on issue and increments each WAIT cycle; reaching MAX_WAIT without memDone SHALL enter ERR.
REQ-020 SHALL, on a memop with inXOut[0]=1, issue no request, enter ERR, set outErr next edge and emit no slot.
REQ-021 SHALL, in ERR, hold stall=1, outValid=0 and outErr=1 until reset; memDone in ERR SHALL be ignored.
REQ-022 SHALL select outWriteData as inPlusTwoPC if inLink=1, else memDataOut if inMemoryToRegister=1, else inXOut.
REQ-023 SHALL force outRegisterWrite=0 for stores.
REQ-024 SHALL, on any slot with outValid=0, force outRegisterWrite, outHalt and outCreateDump to 0.
REQ-025 SHALL, after a slot with outHalt=1 has been emitted, accept no further memops, holding stall=1.
REQ-026 SHALL ignore memStall except for reporting; completion SHALL be defined solely by memDone.

Reset
REQ-027 SHALL, when rst=0 (asynchronous), force state IDLE, wait counter 0, all out* outputs 0 (outErr included), stall=0, memEnable=0 and memWr=0.
REQ-028 SHALL treat reset asserted mid-WAIT as abandoning the request; a memDone arriving after release SHALL be ignored in IDLE.

Structure
REQ-029 SHALL take the FSM state encoding, the 16-bit word width and the MAX_WAIT default from the shared processor package.
REQ-030 SHALL instantiate one sub-module, memwb_slot, as the registered MEM/WB output bank (reset-to-zero dff array); the FSM and counter SHALL sit in the top module.

Verification
REQ-031 SHALL verify: ALU op, inXOut=0x1234, inRegisterWrite=1 -> next cycle outWriteData=0x1234, outValid=1, stall never asserted.
REQ-032 SHALL verify: load from 0x0040, memDone 3 cycles after issue, memDataOut=0xBEEF -> stall high for 3 cycles, one memEnable pulse, outWriteData=0xBEEF.
REQ-033 SHALL verify: store to 0x0003 -> no memEnable, outErr=1 next cycle, stall stays 1 until reset.
REQ-034 SHALL verify: load with memDone never asserted, MAX_WAIT=15 -> ERR after 15 WAIT cycles, outErr=1.
REQ-035 SHALL verify: JAL-style slot with inLink=1 and inPlusTwoPC=0x0102 -> outWriteData=0x0102.
REQ-036 SHALL verify: rst dropped mid-WAIT, then a late memDone -> all outputs 0, state IDLE, no slot emitted.
